// File: rtl/legv8_pkg.sv
// LEGv8 decode package: control bundle, opcodes,
// ALUOp encodings and immediate formats.
package legv8_pkg;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       memto_reg;
    logic       alu_src;
    logic [1:0] alu_op;
  } ctrl_t;

  typedef enum logic [1:0] {
    IMM_NONE,
    IMM_D,
    IMM_CB,
    IMM_B
  } imm_fmt_e;

  localparam logic [1:0] ALU_MEM = 2'b00;
  localparam logic [1:0] ALU_CB  = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;

  localparam logic [10:0] OP_LDUR = 11'b111_1100_0010;
  localparam logic [10:0] OP_STUR = 11'b111_1100_0000;
  localparam logic [10:0] OP_ADD  = 11'b100_0101_1000;
  localparam logic [10:0] OP_SUB  = 11'b110_0101_1000;
  localparam logic [10:0] OP_AND  = 11'b100_0101_0000;
  localparam logic [10:0] OP_ORR  = 11'b101_0101_0000;
  localparam logic [10:0] OP_BR   = 11'b110_1011_0000;
  localparam logic [7:0]  OP_CBZ  = 8'b1011_0100;
  localparam logic [7:0]  OP_CBNZ = 8'b1011_0101;
  localparam logic [5:0]  OP_B    = 6'b00_0101;
  localparam logic [5:0]  OP_BL   = 6'b10_0101;

  localparam ctrl_t CTRL_R =
    '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_R};
  localparam ctrl_t CTRL_LDUR =
    '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, ALU_MEM};
  localparam ctrl_t CTRL_STUR =
    '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, ALU_MEM};
  localparam ctrl_t CTRL_CB =
    '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_CB};

endpackage

// File: rtl/decode_stage_p_regfile.sv
// Register file: zero register, write-through
// bypass on reads, WB port plus BL link port.
module regfile_p #(
  parameter int XLEN     = 64,
  parameter int NREG     = 32,
  parameter int ZR_IDX   = NREG - 1,
  parameter int LINK_IDX = 30,
  parameter int RW       = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RW-1:0]   ra1,
  input  logic [RW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            wb_we,
  input  logic [RW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            lk_we,
  input  logic [XLEN-1:0] lk_data
);

  localparam logic [RW-1:0] ZR = RW'(ZR_IDX);

  logic [XLEN-1:0] regs [NREG];

  // Array update; the link write lands last so it wins on X30
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (wb_we && wb_rd != ZR) regs[wb_rd] <= wb_data;
      if (lk_we) regs[LINK_IDX] <= lk_data;
    end
  end

  // Reads with same-cycle WB bypass, zero register forced last
  always_comb begin
    rd1 = regs[ra1];
    rd2 = regs[ra2];
    if (wb_we && wb_rd == ra1) rd1 = wb_data;
    if (wb_we && wb_rd == ra2) rd2 = wb_data;
    if (ra1 == ZR) rd1 = '0;
    if (ra2 == ZR) rd2 = '0;
  end

endmodule

// File: rtl/decode_stage_p.sv
// LEGv8 decode stage: control decode, hazards,
// early branch resolution and ID/EX register.
module decode_stage_p
  import legv8_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int NREG     = 32,
  parameter int ZR_IDX   = NREG - 1,
  parameter int LINK_IDX = 30,
  parameter int RW       = $clog2(NREG)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [31:0]     instruction,
  input  logic            if_id_valid,
  input  logic [XLEN-1:0] pc_in,
  input  logic            wb_regwrite,
  input  logic [RW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            mem_regwrite,
  input  logic            mem_memread,
  input  logic [RW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_alu_result,
  input  logic            ex_flush,
  output logic            stall_out,
  output logic            if_id_flush,
  output logic [XLEN-1:0] branch_target,
  output ctrl_t           idex_ctrl,
  output logic [XLEN-1:0] idex_rdata1,
  output logic [XLEN-1:0] idex_rdata2,
  output logic [XLEN-1:0] idex_imm,
  output logic [XLEN-1:0] idex_pc,
  output logic [RW-1:0]   idex_rs1,
  output logic [RW-1:0]   idex_rs2,
  output logic [RW-1:0]   idex_rd
);

  localparam logic [RW-1:0] ZR = RW'(ZR_IDX);

  logic [10:0] op;
  logic is_ldur, is_stur, is_r, is_br;
  logic is_cbz, is_cbnz, is_b, is_bl, is_cbr;
  ctrl_t ctrl;
  imm_fmt_e fmt;
  logic use1, use2;
  logic [RW-1:0] rs1, rs2, rd, bop;
  logic [XLEN-1:0] imm, rdata1, rdata2;
  logic [XLEN-1:0] bop_val;
  logic fwd, lu_hz, br_hz, hz;
  logic go, taken, bubble, link_we;

  assign op      = instruction[31:21];
  assign is_ldur = op == OP_LDUR;
  assign is_stur = op == OP_STUR;
  assign is_r    = op == OP_ADD || op == OP_SUB
                || op == OP_AND || op == OP_ORR;
  assign is_br   = op == OP_BR;
  assign is_cbz  = op[10:3] == OP_CBZ;
  assign is_cbnz = op[10:3] == OP_CBNZ;
  assign is_b    = op[10:5] == OP_B;
  assign is_bl   = op[10:5] == OP_BL;
  assign is_cbr  = is_cbz || is_cbnz || is_br;

  // Opcode to control bundle, immediate format, operand use
  always_comb begin
    ctrl = '0;
    fmt  = IMM_NONE;
    use1 = 1'b0;
    use2 = 1'b0;
    unique case (1'b1)
      is_ldur: begin
        ctrl = CTRL_LDUR; fmt = IMM_D; use1 = 1'b1;
      end
      is_stur: begin
        ctrl = CTRL_STUR; fmt = IMM_D;
        use1 = 1'b1; use2 = 1'b1;
      end
      is_r: begin
        ctrl = CTRL_R; use1 = 1'b1; use2 = 1'b1;
      end
      is_cbz, is_cbnz: begin
        ctrl = CTRL_CB; fmt = IMM_CB; use2 = 1'b1;
      end
      is_b, is_bl: fmt = IMM_B;
      is_br: use1 = 1'b1;
      default: ;
    endcase
  end

  assign rs1 = RW'(instruction[9:5]);
  assign rs2 = is_r ? RW'(instruction[20:16])
                    : RW'(instruction[4:0]);
  assign rd  = RW'(instruction[4:0]);

  // Sign-extended immediate for the decoded format
  always_comb begin
    imm = '0;
    case (fmt)
      IMM_D:  imm = {{(XLEN-9){instruction[20]}},
                     instruction[20:12]};
      IMM_CB: imm = {{(XLEN-19){instruction[23]}},
                     instruction[23:5]};
      IMM_B:  imm = {{(XLEN-26){instruction[25]}},
                     instruction[25:0]};
      default: imm = '0;
    endcase
  end

  regfile_p #(
    .XLEN(XLEN), .NREG(NREG), .ZR_IDX(ZR_IDX),
    .LINK_IDX(LINK_IDX), .RW(RW)
  ) u_rf (
    .clk(clock),
    .rst_n(reset),
    .ra1(rs1),
    .ra2(rs2),
    .rd1(rdata1),
    .rd2(rdata2),
    .wb_we(wb_regwrite),
    .wb_rd(wb_rd),
    .wb_data(wb_data),
    .lk_we(link_we),
    .lk_data(pc_in + XLEN'(4))
  );

  // BR tests Rn, CBZ/CBNZ test Rt
  assign bop = is_br ? rs1 : rs2;
  assign fwd = mem_regwrite && !mem_memread
            && mem_rd == bop && bop != ZR;
  assign bop_val = fwd ? mem_alu_result
                 : (is_br ? rdata1 : rdata2);

  assign lu_hz = idex_ctrl.mem_read && idex_rd != ZR
              && ((use1 && idex_rd == rs1)
               || (use2 && idex_rd == rs2));
  assign br_hz = is_cbr && bop != ZR
              && ((idex_ctrl.reg_write && idex_rd == bop)
               || (mem_memread && mem_rd == bop));
  assign hz = reset && if_id_valid && (lu_hz || br_hz);

  assign go    = reset && if_id_valid && !hz;
  assign taken = go && (is_b || is_bl || is_br
              || (is_cbz && bop_val == '0)
              || (is_cbnz && bop_val != '0));

  assign stall_out     = hz;
  assign if_id_flush   = taken;
  assign link_we       = taken && is_bl;
  assign branch_target = is_br ? bop_val
                       : pc_in + {imm[XLEN-3:0], 2'b00};
  assign bubble = !go || ex_flush || taken;

  // ID/EX register; bubbles clear every field
  always_ff @(posedge clock or negedge reset) begin
    if (!reset || bubble) begin
      idex_ctrl   <= '0;
      idex_rdata1 <= '0;
      idex_rdata2 <= '0;
      idex_imm    <= '0;
      idex_pc     <= '0;
      idex_rs1    <= '0;
      idex_rs2    <= '0;
      idex_rd     <= '0;
    end else begin
      idex_ctrl   <= ctrl;
      idex_rdata1 <= rdata1;
      idex_rdata2 <= rdata2;
      idex_imm    <= imm;
      idex_pc     <= pc_in;
      idex_rs1    <= rs1;
      idex_rs2    <= rs2;
      idex_rd     <= rd;
    end
  end

endmodule

// File: tb/tb_decode_stage_p.sv
// Directed bench for decode_stage_p: regfile,
// hazards, branch resolution and ID/EX bubbles.
module tb_decode_stage_p;
  import legv8_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        if_id_valid;
  logic [63:0] pc_in;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        mem_regwrite, mem_memread;
  logic [4:0]  mem_rd;
  logic [63:0] mem_alu_result;
  logic        ex_flush;
  logic        stall_out, if_id_flush;
  logic [63:0] branch_target;
  ctrl_t       idex_ctrl;
  logic [63:0] idex_rdata1, idex_rdata2;
  logic [63:0] idex_imm, idex_pc;
  logic [4:0]  idex_rs1, idex_rs2, idex_rd;

  int nchk = 0;
  int nfail = 0;

  localparam logic [63:0] C_R    = 64'b1000010;
  localparam logic [63:0] C_LDUR = 64'b1101100;
  localparam logic [63:0] C_STUR = 64'b0010100;
  localparam logic [63:0] C_CB   = 64'b0000001;

  decode_stage_p dut (
    .clock(clock), .reset(reset),
    .instruction(instruction),
    .if_id_valid(if_id_valid), .pc_in(pc_in),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .wb_data(wb_data),
    .mem_regwrite(mem_regwrite),
    .mem_memread(mem_memread), .mem_rd(mem_rd),
    .mem_alu_result(mem_alu_result),
    .ex_flush(ex_flush), .stall_out(stall_out),
    .if_id_flush(if_id_flush),
    .branch_target(branch_target),
    .idex_ctrl(idex_ctrl),
    .idex_rdata1(idex_rdata1),
    .idex_rdata2(idex_rdata2),
    .idex_imm(idex_imm), .idex_pc(idex_pc),
    .idex_rs1(idex_rs1), .idex_rs2(idex_rs2),
    .idex_rd(idex_rd)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] r_i(
    input logic [10:0] o, input int d, n, m);
    return {o, 5'(m), 6'd0, 5'(n), 5'(d)};
  endfunction

  function automatic logic [31:0] d_i(
    input logic [10:0] o, input int t, n, im);
    return {o, 9'(im), 2'b00, 5'(n), 5'(t)};
  endfunction

  function automatic logic [31:0] cb_i(
    input logic [7:0] o, input int t, im);
    return {o, 19'(im), 5'(t)};
  endfunction

  function automatic logic [31:0] b_i(
    input logic [5:0] o, input int im);
    return {o, 26'(im)};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
    input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %h expected %h",
             tag, got, exp);
    end
  endtask

  task automatic wb(input logic en, input int r,
    input logic [63:0] d);
    wb_regwrite = en;
    wb_rd = 5'(r);
    wb_data = d;
  endtask

  initial begin
    reset = 1'b0;
    instruction = b_i(OP_B, 3);
    if_id_valid = 1'b1;
    pc_in = 64'h40;
    wb(1'b1, 5, 64'hDEAD);
    mem_regwrite = 1'b1;
    mem_memread = 1'b1;
    mem_rd = 5'd7;
    mem_alu_result = 64'h9;
    ex_flush = 1'b0;
    tick();
    tick();
    chk("rst_flush", 64'(if_id_flush), 64'd0);
    chk("rst_ctrl", 64'(idex_ctrl), 64'd0);
    chk("rst_pc", idex_pc, 64'd0);
    chk("rst_imm", idex_imm, 64'd0);
    instruction = cb_i(OP_CBZ, 7, 4);
    #1;
    chk("rst_stall", 64'(stall_out), 64'd0);

    reset = 1'b1;
    if_id_valid = 1'b0;
    wb(1'b0, 0, 64'd0);
    mem_regwrite = 1'b0;
    mem_memread = 1'b0;
    tick();

    instruction = r_i(OP_ADD, 1, 5, 5);
    if_id_valid = 1'b1;
    pc_in = 64'h10;
    tick();
    chk("x5_ctrl", 64'(idex_ctrl), C_R);
    chk("x5_rd1", idex_rdata1, 64'd0);
    chk("x5_rd2", idex_rdata2, 64'd0);
    chk("x5_pc", idex_pc, 64'h10);

    instruction = r_i(OP_ADD, 1, 3, 2);
    wb(1'b1, 3, 64'h1234);
    tick();
    chk("byp_rd1", idex_rdata1, 64'h1234);
    chk("byp_rs1", 64'(idex_rs1), 64'd3);
    chk("byp_rs2", 64'(idex_rs2), 64'd2);
    chk("byp_rd", 64'(idex_rd), 64'd1);
    wb(1'b0, 0, 64'd0);

    instruction = d_i(OP_STUR, 3, 1, -8);
    tick();
    chk("stur_ctrl", 64'(idex_ctrl), C_STUR);
    chk("stur_imm", idex_imm, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("stur_rd2", idex_rdata2, 64'h1234);
    chk("stur_rs2", 64'(idex_rs2), 64'd3);

    instruction = d_i(OP_LDUR, 2, 3, 8);
    tick();
    chk("ldur_ctrl", 64'(idex_ctrl), C_LDUR);
    chk("ldur_rd", 64'(idex_rd), 64'd2);
    chk("ldur_imm", idex_imm, 64'd8);
    chk("ldur_rd1", idex_rdata1, 64'h1234);

    instruction = r_i(OP_ADD, 4, 2, 2);
    #1;
    chk("lu_stall", 64'(stall_out), 64'd1);
    tick();
    chk("lu_bubble", 64'(idex_ctrl), 64'd0);
    chk("lu_release", 64'(stall_out), 64'd0);
    tick();
    chk("lu_issue", 64'(idex_ctrl), C_R);
    chk("lu_issue_rd", 64'(idex_rd), 64'd4);

    instruction = cb_i(OP_CBZ, 7, 4);
    pc_in = 64'h100;
    #1;
    chk("cbz_flush", 64'(if_id_flush), 64'd1);
    chk("cbz_tgt", branch_target, 64'h110);
    chk("cbz_stall", 64'(stall_out), 64'd0);
    tick();
    chk("cbz_bubble", 64'(idex_ctrl), 64'd0);

    wb(1'b1, 7, 64'd5);
    #1;
    chk("cbz5_flush", 64'(if_id_flush), 64'd0);
    tick();
    chk("cbz5_ctrl", 64'(idex_ctrl), C_CB);
    chk("cbz5_imm", idex_imm, 64'd4);

    if_id_valid = 1'b0;
    wb(1'b1, 9, 64'h55);
    tick();
    chk("inv_bubble", 64'(idex_ctrl), 64'd0);
    wb(1'b0, 0, 64'd0);

    instruction = cb_i(OP_CBNZ, 9, 8);
    if_id_valid = 1'b1;
    pc_in = 64'h300;
    mem_regwrite = 1'b1;
    mem_rd = 5'd9;
    mem_alu_result = 64'd0;
    #1;
    chk("fwd_flush", 64'(if_id_flush), 64'd0);
    chk("fwd_stall", 64'(stall_out), 64'd0);
    tick();
    chk("fwd_ctrl", 64'(idex_ctrl), C_CB);
    mem_memread = 1'b1;
    #1;
    chk("mrd_stall", 64'(stall_out), 64'd1);
    chk("mrd_flush", 64'(if_id_flush), 64'd0);
    tick();
    chk("mrd_bubble", 64'(idex_ctrl), 64'd0);
    mem_memread = 1'b0;
    mem_regwrite = 1'b0;
    #1;
    chk("mrd_go", 64'(stall_out), 64'd0);
    chk("mrd_taken", 64'(if_id_flush), 64'd1);
    chk("mrd_tgt", branch_target, 64'h320);
    tick();

    instruction = b_i(OP_BL, 16);
    pc_in = 64'h200;
    wb(1'b1, 30, 64'hAA);
    #1;
    chk("bl_flush", 64'(if_id_flush), 64'd1);
    chk("bl_tgt", branch_target, 64'h240);
    tick();
    chk("bl_bubble", 64'(idex_ctrl), 64'd0);

    instruction = r_i(OP_ADD, 1, 30, 31);
    wb(1'b1, 31, 64'h77);
    tick();
    chk("link_x30", idex_rdata1, 64'h204);
    chk("zr_byp", idex_rdata2, 64'd0);
    wb(1'b0, 0, 64'd0);
    instruction = r_i(OP_ADD, 1, 31, 31);
    tick();
    chk("zr_read", idex_rdata1, 64'd0);

    instruction = r_i(OP_ADD, 1, 3, 3);
    ex_flush = 1'b1;
    tick();
    chk("exf_bubble", 64'(idex_ctrl), 64'd0);
    ex_flush = 1'b0;

    instruction = d_i(OP_LDUR, 2, 3, 8);
    tick();
    instruction = r_i(OP_ADD, 4, 2, 2);
    ex_flush = 1'b1;
    #1;
    chk("exf_stall", 64'(stall_out), 64'd1);
    tick();
    chk("exf_st_bub", 64'(idex_ctrl), 64'd0);
    ex_flush = 1'b0;

    instruction = d_i(OP_LDUR, 6, 3, 0);
    tick();
    instruction = cb_i(OP_CBZ, 6, 2);
    pc_in = 64'h400;
    #1;
    chk("bst_1", 64'(stall_out), 64'd1);
    tick();
    mem_memread = 1'b1;
    mem_regwrite = 1'b1;
    mem_rd = 5'd6;
    #1;
    chk("bst_2", 64'(stall_out), 64'd1);
    tick();
    mem_memread = 1'b0;
    mem_regwrite = 1'b0;
    wb(1'b1, 6, 64'd0);
    #1;
    chk("bst_done", 64'(stall_out), 64'd0);
    chk("bst_flush", 64'(if_id_flush), 64'd1);
    chk("bst_tgt", branch_target, 64'h408);
    tick();
    wb(1'b0, 0, 64'd0);

    instruction = d_i(OP_LDUR, 2, 3, 8);
    tick();
    instruction = r_i(OP_ADD, 4, 2, 2);
    #1;
    chk("rs_stall", 64'(stall_out), 64'd1);
    reset = 1'b0;
    #1;
    chk("rs_clr", 64'(stall_out), 64'd0);
    chk("rs_ctrl", 64'(idex_ctrl), 64'd0);
    chk("rs_rd", 64'(idex_rd), 64'd0);
    tick();
    reset = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule

// File: doc/decode_stage_p.md
# decode_stage_p

Parametrised decode stage for the pipelined LEGv8/ARMv8 core: register file, control decode, load-use and branch hazard detection, early branch resolution and a registered ID/EX pipeline register. Sits between the IF/ID register and the execute stage. Compared with the previous decode block it adds configurable width and register count, a hardwired zero register, write-through bypass, in-block stall generation and bubble insertion, and forwarding of MEM-stage results to the branch compare.

## Interface
- XLEN, 64: datapath width.
- NREG, 32: architectural registers; address width RW = $clog2(NREG).
- ZR_IDX, NREG-1: zero register index; reads 0, writes ignored.
- LINK_IDX, 30: BL link register.

Ports:
- clock  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- instruction  in  32  instruction from IF/ID.
- if_id_valid  in  1  IF/ID holds a real instruction.
- pc_in  in  XLEN  PC of that instruction.
- wb_regwrite / wb_rd / wb_data  in  1 / RW / XLEN  write-back port.
- mem_regwrite / mem_memread / mem_rd / mem_alu_result  in  1 / 1 / RW / XLEN  MEM-stage state for branch forwarding.
- ex_flush  in  1  squash the instruction entering ID/EX.
- stall_out  out  1  hold PC and IF/ID this cycle.
- if_id_flush  out  1  branch taken; squash IF/ID.
- branch_target  out  XLEN  redirect PC.
- idex_ctrl  out  ctrl_t  registered control bundle (RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, ALUOp[1:0]).
- idex_rdata1 / idex_rdata2 / idex_imm / idex_pc  out  XLEN  registered operands, sign-extended immediate, PC.
- idex_rs1 / idex_rs2 / idex_rd  out  RW  registered register indices for forwarding.

## Operation
- Decode on instruction[31:21]: LDUR, STUR, ADD, SUB, AND, ORR, CBZ, CBNZ, B, BL, BR; anything else decodes to all-zero control (NOP).
- rs1 = [9:5]; rs2 = [20:16] for R-type, [4:0] for STUR/CBZ/CBNZ; rd = [4:0].
- Immediate: D-type [20:12], CB [23:5], B/BL [25:0], each sign-extended to XLEN.
- Register file: NREG×XLEN, cleared on reset. ZR_IDX reads 0. Write-through: a read of wb_rd while wb_regwrite returns wb_data in the same cycle.
- Load-use stall: idex_ctrl.MemRead and idex_rd ∈ {rs1, rs2 used} and idex_rd≠ZR_IDX.
- Branch-operand stall (CBZ/CBNZ/BR): idex RegWrite to the branch operand, or mem_memread with mem_rd equal to the branch operand.
- Branch forwarding: mem_regwrite, !mem_memread and mem_rd == branch operand (≠ZR) selects mem_alu_result over the register-file value.
- Taken: B, BL, BR always; CBZ if operand==0; CBNZ if operand≠0. branch_target = pc_in + (imm<<2), or operand for BR.
- BL: writes pc_in+4 to LINK_IDX at the edge via internal link port. If wb_rd==LINK_IDX in the same cycle, the link value wins.
- All decode outputs are qualified by if_id_valid && !stall_out. An unqualified instruction produces no flush, no link write, and a bubble.

## Timing
- stall_out, if_id_flush and branch_target are combinational in the same cycle. A stall suppresses if_id_flush.
- ID/EX latency is 1 cycle. A bubble (all fields 0) is loaded when stalled, ex_flush, !if_id_valid, or taken branch/B/BL/BR (no EX work).
- Reset: every idex_* output is 0, the register file is 0, and stall_out/if_id_flush are 0 while reset is low. Reset asserted mid-stall clears the stall and the bubble state immediately.
- ex_flush together with stall: a bubble is loaded and stall_out still reflects the hazard.
- A load-use stall lasts exactly 1 cycle. A branch stall behind a load lasts 2 cycles.

## Structure
- Package legv8_pkg holds ctrl_t, the opcode constants, the ALUOp encodings and the immediate-format enum.
- Sub-module regfile_p holds the register array, ZR, bypass and the two write ports. Decode, hazard and ID/EX logic live in the top.

## Test plan
- Reset low with arbitrary inputs -> all idex_* are 0. After release, reading X5 returns 0.
- WB writes X3=0x1234 while ADD X1,X3,X2 is in ID -> idex_rdata1=0x1234 on the next edge.
- LDUR X2 in ID/EX, ADD X4,X2,X2 in ID -> stall_out=1 for 1 cycle and a bubble in ID/EX, then the ADD issues.
- CBZ X7 with X7=0, offset 4, pc_in=0x100 -> if_id_flush=1, branch_target=0x110. With X7=5 -> no flush.
- CBNZ X9 while MEM holds ALU result 0 for X9 -> forwarded value used, not taken. Same case with mem_memread=1 -> 1 stall cycle.
- BL at pc 0x200 while WB writes X30=0xAA -> X30=0x204 afterwards. A write to X31 is ignored and X31 reads 0.
